multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: opcode  input  6  IR[31:26], valid from ID onward.
REQ-005 SHALL have port: funct  input  6  IR[5:0].
REQ-006 SHALL have port: mem_ready  input  1  shared memory done this cycle; combinational same-cycle ready allowed.
REQ-007 SHALL have outputs mem_req 1, mem_we 1 and iord 1 (0 = PC address, 1 = ALUOut address).
REQ-008 SHALL have outputs ir_write 1, pc_write 1, pc_write_cond 1 and epc_write 1.
REQ-009 SHALL have outputs pc_src 3 (000 PC+4, 001 branch, 010 j-target, 011 rs, 100 exception vector) and reg_write 1.
REQ-010 SHALL have outputs reg_dst 2 (00 rt, 01 rd, 10 $ra, 11 $k0) and mem_to_reg 2 (00 ALU, 01 MDR, 10 PC).
REQ-011 SHALL have outputs alu_src_a 1, alu_src_b 2, inst_done 1 (one-cycle retire pulse) and state 4 (debug).

Function
REQ-012 SHALL implement states IF, ID, EX, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BR, JMP and EXC.
REQ-013 SHALL drive all outputs to 0 in every state except where a listed rule asserts them.
REQ-014 In IF, SHALL assert mem_req with iord=0 and hold it until mem_ready; in the mem_ready cycle it SHALL assert ir_write and pc_write with pc_src=000, then go to ID.
REQ-015 In ID, SHALL decode opcode/funct and go to EXC for an illegal encoding.
REQ-016 In ID, SHALL go to BR for 04/05/06/07/01.
REQ-017 In ID, SHALL go to JMP for 02/03 and for R-type funct 08/09.
REQ-018 In ID, SHALL go to EX for all other legal encodings.
REQ-019 Legal set SHALL be: I-type 0f/08/09/0c/0d/0a/0b/23/2b; jump/branch 01–07; R-type funct 00/02/03/08/09/20–27/2a/2b.
REQ-020 From EX, SHALL go to MEM_RD for lw (23), to MEM_WR for sw (2b), and to WB_ALU otherwise.
REQ-021 In EX, SHALL set alu_src_b=10 (immediate) for I-type and alu_src_b=00 for R-type; it SHALL set alu_src_a=1 for shifts 00/02/03.
REQ-022 In MEM_RD, SHALL hold mem_req with iord=1 until mem_ready, then go to WB_MEM.
REQ-023 In MEM_WR, SHALL hold mem_req and mem_we with iord=1 until mem_ready, then go to IF with inst_done=1.
REQ-024 WB_ALU SHALL assert reg_write with reg_dst=01 for R-type and 00 otherwise, and mem_to_reg=00; WB_MEM SHALL assert reg_write with reg_dst=00 and mem_to_reg=01; both SHALL go to IF with inst_done=1.
REQ-025 BR SHALL assert pc_write_cond with pc_src=001, then go to IF with inst_done=1.
REQ-026 JMP SHALL assert pc_write with pc_src=010 for j/jal and 011 for jr/jalr.
REQ-027 JMP SHALL assert reg_write with mem_to_reg=10 for jal (reg_dst=10) and for jalr (reg_dst=01); it SHALL then go to IF with inst_done=1.
REQ-028 EXC SHALL assert epc_write, pc_write with pc_src=100, and reg_write with reg_dst=11 and mem_to_reg=10; it SHALL then go to IF with inst_done=0.
REQ-029 mem_req SHALL never be asserted outside IF, MEM_RD and MEM_WR, and iord/mem_we SHALL stay stable while mem_req is held.
REQ-030 With zero-wait memory, latency SHALL be: R/I-ALU 4 cycles, lw 5, sw 4, branch 3, jump 3, illegal 3 (IF→ID→EXC).
REQ-031 Each memory wait cycle SHALL add exactly one cycle to the latency.

Reset
REQ-032 Reset assertion SHALL immediately force state=IF and all outputs to 0, including a reset in the middle of a memory wait.
REQ-033 The first mem_req after reset SHALL be asserted in the first clk edge cycle after reset deasserts.

Structure
REQ-034 Package mc_ctrl_pkg SHALL hold the state encodings, opcode/funct constants, and the pc_src, reg_dst and mem_to_reg codes.
REQ-035 Sub-module mc_inst_class SHALL be combinational, mapping opcode/funct to the class {ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, ILLEGAL}.
REQ-036 The FSM SHALL hold only a state register and no other storage.

Verification
REQ-037 add (op 00, funct 20) with mem_ready tied 1 -> states IF,ID,EX,WB_ALU; reg_write=1 and reg_dst=01 in cycle 4; inst_done in cycle 4.
REQ-038 lw (23) with mem_ready low 2 cycles in both IF and MEM_RD -> 9 cycles total; mem_req held with iord 0 then 1; reg_write with mem_to_reg=01 in the last cycle.
REQ-039 jal (03) -> cycle 3: pc_write=1, pc_src=010, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-040 opcode 3f -> cycle 3 EXC: epc_write=1, pc_src=100, reg_dst=11; inst_done stays 0.
REQ-041 reset low while in MEM_WR waiting -> same-cycle mem_req=0 and mem_we=0, state=IF; after release, IF resumes fetch.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: FSM states,
// instruction classes, opcode/funct constants and datapath mux select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX     = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_ALU = 4'd5,
        S_WB_MEM = 4'd6,
        S_BR     = 4'd7,
        S_JMP    = 4'd8,
        S_EXC    = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_R   = 3'd0,
        C_ALU_I   = 3'd1,
        C_LOAD    = 3'd2,
        C_STORE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_JUMP    = 3'd5,
        C_ILLEGAL = 3'd6
    } inst_class_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam logic [2:0] PC_SRC_PLUS4  = 3'b000;
    localparam logic [2:0] PC_SRC_BRANCH = 3'b001;
    localparam logic [2:0] PC_SRC_JTGT   = 3'b010;
    localparam logic [2:0] PC_SRC_RS     = 3'b011;
    localparam logic [2:0] PC_SRC_EXC    = 3'b100;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;
    localparam logic [1:0] REG_DST_K0 = 2'b11;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] ALU_B_REG = 2'b00;
    localparam logic [1:0] ALU_B_IMM = 2'b10;

    // Shifts take their A operand from the shamt field instead of rs.
    function automatic logic is_shift(input logic [5:0] f);
        return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
    endfunction

endpackage

// File: rtl/mc_inst_class.sv
// Combinational decoder mapping opcode/funct onto an instruction class.
module mc_inst_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] inst_class
);

    always_comb begin
        inst_class = C_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                if (funct inside {F_SLL, F_SRL, F_SRA, [F_ADD:F_NOR], F_SLT, F_SLTU})
                    inst_class = C_ALU_R;
                else if (funct inside {F_JR, F_JALR})
                    inst_class = C_JUMP;
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                inst_class = C_BRANCH;
            OP_J, OP_JAL:
                inst_class = C_JUMP;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI:
                inst_class = C_ALU_I;
            OP_LW:   inst_class = C_LOAD;
            OP_SW:   inst_class = C_STORE;
            default: inst_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM. The only storage is the state register;
// the instruction class is re-decoded from the live IR fields in every state.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       epc_write,
    output logic [2:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       inst_done,
    output logic [3:0] state
);

    state_t      cur_state;
    state_t      nxt_state;
    logic [2:0]  class_raw;
    inst_class_t iclass;
    logic        r_type;

    mc_inst_class u_inst_class (
        .opcode     (opcode),
        .funct      (funct),
        .inst_class (class_raw)
    );

    assign iclass = inst_class_t'(class_raw);
    assign r_type = (opcode == OP_RTYPE);
    assign state  = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= S_IF;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_IF;
        case (cur_state)
            S_IF:     nxt_state = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (iclass)
                    C_ILLEGAL: nxt_state = S_EXC;
                    C_BRANCH:  nxt_state = S_BR;
                    C_JUMP:    nxt_state = S_JMP;
                    default:   nxt_state = S_EX;
                endcase
            end
            S_EX: begin
                case (iclass)
                    C_LOAD:  nxt_state = S_MEM_RD;
                    C_STORE: nxt_state = S_MEM_WR;
                    default: nxt_state = S_WB_ALU;
                endcase
            end
            S_MEM_RD: nxt_state = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: nxt_state = mem_ready ? S_IF : S_MEM_WR;
            default:  nxt_state = S_IF;
        endcase
    end

    // Outputs are gated by reset so an asserted reset silences the memory
    // request in the same cycle, not only after the state register clears.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        epc_write     = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        reg_write     = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = M2R_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_B_REG;
        inst_done     = 1'b0;
        if (reset) begin
            case (cur_state)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_EX: begin
                    if (iclass == C_ALU_R) begin
                        alu_src_b = ALU_B_REG;
                        alu_src_a = is_shift(funct);
                    end else begin
                        alu_src_b = ALU_B_IMM;
                    end
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    iord      = 1'b1;
                    inst_done = mem_ready;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = r_type ? REG_DST_RD : REG_DST_RT;
                    inst_done = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    inst_done  = 1'b1;
                end
                S_BR: begin
                    pc_write_cond = 1'b1;
                    pc_src        = PC_SRC_BRANCH;
                    inst_done     = 1'b1;
                end
                S_JMP: begin
                    pc_write  = 1'b1;
                    inst_done = 1'b1;
                    if (r_type) begin
                        pc_src = PC_SRC_RS;
                        if (funct == F_JALR) begin
                            reg_write  = 1'b1;
                            reg_dst    = REG_DST_RD;
                            mem_to_reg = M2R_PC;
                        end
                    end else begin
                        pc_src = PC_SRC_JTGT;
                        if (opcode == OP_JAL) begin
                            reg_write  = 1'b1;
                            reg_dst    = REG_DST_RA;
                            mem_to_reg = M2R_PC;
                        end
                    end
                end
                S_EXC: begin
                    epc_write  = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_EXC;
                    reg_write  = 1'b1;
                    reg_dst    = REG_DST_K0;
                    mem_to_reg = M2R_PC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control checks
// against hand-computed sequences for each instruction class.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, epc_write;
    logic [2:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       inst_done;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .epc_write     (epc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .inst_done     (inst_done),
        .state         (state)
    );

    // Advance one cycle: drive mem_ready just after the edge, observe at the falling edge.
    task automatic cyc(input logic mr);
        @(posedge clk);
        #1 mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [18:0] all_out;
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        all_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, epc_write,
                   pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, inst_done};
        tests_run++;
        if (all_out !== 19'd0 || state !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got outs=%h state=%0d expected outs=0 state=0", all_out, state);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, iord, ir_write, pc_write, state} !== 8'b1_0_0_0_0000) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got req=%b iord=%b irw=%b pcw=%b st=%0d expected 1 0 0 0 0",
                     mem_req, iord, ir_write, pc_write, state);
        end
    endtask

    task automatic test_add();
        logic [3:0] exp_st [4];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
        opcode = 6'h00;
        funct  = 6'h20;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            tests_run++;
            if (state !== exp_st[i] || inst_done !== (i == 3)) begin
                tests_failed++;
                $display("FAIL add_seq c%0d: got st=%0d done=%b expected st=%0d done=%b",
                         i + 1, state, inst_done, exp_st[i], (i == 3));
            end
            if (i == 0) begin
                tests_run++;
                if ({mem_req, iord, ir_write, pc_write, pc_src} !== 7'b1_0_1_1_000) begin
                    tests_failed++;
                    $display("FAIL add_fetch: got %b expected 1011000",
                             {mem_req, iord, ir_write, pc_write, pc_src});
                end
            end
            if (i == 2) begin
                tests_run++;
                if ({mem_req, alu_src_a, alu_src_b} !== 4'b0_0_00) begin
                    tests_failed++;
                    $display("FAIL add_ex: got %b expected 0000", {mem_req, alu_src_a, alu_src_b});
                end
            end
            if (i == 3) begin
                tests_run++;
                if ({reg_write, reg_dst, mem_to_reg} !== 5'b1_01_00) begin
                    tests_failed++;
                    $display("FAIL add_wb: got %b expected 10100", {reg_write, reg_dst, mem_to_reg});
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp_st [9];
        logic       mr [9];
        logic       exp_req, exp_iord;
        exp_st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd6};
        mr     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'h23;
        funct  = 6'h00;
        for (int i = 0; i < 9; i++) begin
            cyc(mr[i]);
            exp_req  = (i <= 2) || (i >= 5 && i <= 7);
            exp_iord = (i >= 5 && i <= 7);
            tests_run++;
            if (state !== exp_st[i] || mem_req !== exp_req || iord !== exp_iord || mem_we !== 1'b0
                || ir_write !== (i == 2) || inst_done !== (i == 8)) begin
                tests_failed++;
                $display("FAIL lw_seq c%0d: got st=%0d req=%b iord=%b we=%b irw=%b done=%b expected st=%0d req=%b iord=%b we=0 irw=%b done=%b",
                         i + 1, state, mem_req, iord, mem_we, ir_write, inst_done,
                         exp_st[i], exp_req, exp_iord, (i == 2), (i == 8));
            end
        end
        tests_run++;
        if ({reg_write, reg_dst, mem_to_reg} !== 5'b1_00_01) begin
            tests_failed++;
            $display("FAIL lw_wb: got %b expected 10001", {reg_write, reg_dst, mem_to_reg});
        end
    endtask

    task automatic test_jumps();
        logic [5:0] ops [3];
        logic [5:0] fns [3];
        logic [9:0] exp_o [3];
        logic [9:0] got;
        ops   = '{6'h03, 6'h00, 6'h00};
        fns   = '{6'h00, 6'h08, 6'h09};
        exp_o = '{10'b1_010_1_10_10_1, 10'b1_011_0_00_00_1, 10'b1_011_1_01_10_1};
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            funct  = fns[k];
            cyc(1'b1);
            cyc(1'b1);
            cyc(1'b1);
            got = {pc_write, pc_src, reg_write, reg_dst, mem_to_reg, inst_done};
            tests_run++;
            if (state !== 4'd8 || got !== exp_o[k]) begin
                tests_failed++;
                $display("FAIL jump_%0d: got st=%0d outs=%b expected st=8 outs=%b", k, state, got, exp_o[k]);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2];
        ops = '{6'h04, 6'h01};
        funct = 6'h00;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            cyc(1'b1);
            cyc(1'b1);
            cyc(1'b1);
            tests_run++;
            if (state !== 4'd7 || {pc_write_cond, pc_src, pc_write, inst_done} !== 6'b1_001_0_1) begin
                tests_failed++;
                $display("FAIL branch_op%h: got st=%0d outs=%b expected st=7 outs=100101",
                         ops[k], state, {pc_write_cond, pc_src, pc_write, inst_done});
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        logic [10:0] got;
        ops = '{6'h3f, 6'h00};
        fns = '{6'h00, 6'h01};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            funct  = fns[k];
            for (int i = 0; i < 3; i++) begin
                cyc(1'b1);
                tests_run++;
                if (inst_done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL illegal_done_%0d c%0d: got %b expected 0", k, i + 1, inst_done);
                end
            end
            got = {epc_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg};
            tests_run++;
            if (state !== 4'd9 || got !== 11'b1_1_100_1_11_10 || mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_exc_%0d: got st=%0d outs=%b req=%b expected st=9 outs=11100111110 req=0",
                         k, state, got, mem_req);
            end
        end
    endtask

    task automatic test_ex_operands();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        logic [2:0] exp_ex [2];
        logic [1:0] exp_dst [2];
        ops = '{6'h0d, 6'h00};
        fns = '{6'h00, 6'h00};
        exp_ex  = '{3'b0_10, 3'b1_00};
        exp_dst = '{2'b00, 2'b01};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            funct  = fns[k];
            cyc(1'b1);
            cyc(1'b1);
            cyc(1'b1);
            tests_run++;
            if (state !== 4'd2 || {alu_src_a, alu_src_b} !== exp_ex[k]) begin
                tests_failed++;
                $display("FAIL ex_operands_%0d: got st=%0d ab=%b expected st=2 ab=%b",
                         k, state, {alu_src_a, alu_src_b}, exp_ex[k]);
            end
            cyc(1'b1);
            tests_run++;
            if (state !== 4'd5 || reg_write !== 1'b1 || reg_dst !== exp_dst[k]) begin
                tests_failed++;
                $display("FAIL wb_dst_%0d: got st=%0d rw=%b dst=%b expected st=5 rw=1 dst=%b",
                         k, state, reg_write, reg_dst, exp_dst[k]);
            end
        end
    endtask

    task automatic test_reset_mem_wr();
        opcode = 6'h2b;
        funct  = 6'h00;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        tests_run++;
        if (state !== 4'd4 || {mem_req, mem_we, iord, inst_done} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL sw_wait: got st=%0d outs=%b expected st=4 outs=1110",
                     state, {mem_req, mem_we, iord, inst_done});
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0 || {mem_req, mem_we, iord, inst_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_in_wait: got st=%0d outs=%b expected st=0 outs=0000",
                     state, {mem_req, mem_we, iord, inst_done});
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0 || {mem_req, mem_we, iord} !== 3'b100) begin
            tests_failed++;
            $display("FAIL refetch_after_reset: got st=%0d outs=%b expected st=0 outs=100",
                     state, {mem_req, mem_we, iord});
        end
    endtask

    // Zero-wait program checks the latency of each class and the retire pulse.
    task automatic test_back_to_back();
        logic [5:0] ops [6];
        logic [5:0] fns [6];
        int         lens [6];
        logic       done_exp [6];
        ops      = '{6'h00, 6'h23, 6'h2b, 6'h05, 6'h02, 6'h3e};
        fns      = '{6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        lens     = '{4, 5, 4, 3, 3, 3};
        done_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            opcode = ops[k];
            funct  = fns[k];
            for (int i = 0; i < lens[k]; i++) begin
                cyc(1'b1);
                tests_run++;
                if ((i == 0 && state !== 4'd0) || inst_done !== (done_exp[k] && i == lens[k] - 1)) begin
                    tests_failed++;
                    $display("FAIL b2b_op%h c%0d: got st=%0d done=%b expected done=%b",
                             ops[k], i + 1, state, inst_done, (done_exp[k] && i == lens[k] - 1));
                end
            end
        end
        cyc(1'b0);
        tests_run++;
        if (state !== 4'd0 || mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_return: got st=%0d req=%b expected st=0 req=1", state, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_jumps();
        test_branch();
        test_illegal();
        test_ex_operands();
        test_reset_mem_wr();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
